// File: rtl/cache_ctrl_set_assoc.sv
// N-way set-associative write-back / write-allocate L1 cache controller, one request in flight.
// Optional CACHE_STATS_EN adds saturating first-pass hit/miss counters.
module cache_ctrl_set_assoc #(
  parameter int ADDRESS_WIDTH       = 32,
  parameter int DATA_WIDTH          = 32,
  parameter int MAIN_MEM_DATA_WIDTH = 128,
  parameter int NUM_SETS            = 4,
  parameter int NUM_WAYS            = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cpu_valid,
  input  logic                           cpu_rw,
  input  logic [ADDRESS_WIDTH-1:0]       cpu_addr,
  input  logic [DATA_WIDTH-1:0]          cpu_wdata,
  output logic [DATA_WIDTH-1:0]          cpu_rdata,
  output logic                           cpu_ready,
  output logic                           mem_valid,
  output logic                           mem_rw,
  output logic [ADDRESS_WIDTH-1:0]       mem_addr,
  output logic [MAIN_MEM_DATA_WIDTH-1:0] mem_wdata,
  input  logic [MAIN_MEM_DATA_WIDTH-1:0] mem_rdata,
  input  logic                           mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                    hit_count,
  output logic [31:0]                    miss_count
`endif
);
  localparam int WPB         = MAIN_MEM_DATA_WIDTH / DATA_WIDTH;
  localparam int INDEX_WIDTH = $clog2(NUM_SETS);
  localparam int BYTE_OFF    = $clog2(DATA_WIDTH / 8);
  localparam int WORD_OFF    = $clog2(WPB);
  localparam int OFF_W       = BYTE_OFF + WORD_OFF;
  localparam int TAG_WIDTH   = ADDRESS_WIDTH - INDEX_WIDTH - OFF_W;
  localparam int WAY_W       = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_COMPARE   = 2'd1;
  localparam logic [1:0] S_WRITEBACK = 2'd2;
  localparam logic [1:0] S_ALLOCATE  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic                   req_rw_q, req_rw_d;
  logic [TAG_WIDTH-1:0]   req_tag_q, req_tag_d;
  logic [INDEX_WIDTH-1:0] req_idx_q, req_idx_d;
  logic [WORD_OFF-1:0]    req_word_q, req_word_d;
  logic [DATA_WIDTH-1:0]  req_wdata_q, req_wdata_d;
  logic [WAY_W-1:0]       victim_q, victim_d;
  logic                   mem_gap_q, mem_gap_d;
  logic                   cpu_ready_q, cpu_ready_d;
  logic [DATA_WIDTH-1:0]  cpu_rdata_q, cpu_rdata_d;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, dirty_q;
  logic [TAG_WIDTH-1:0]              tag_q  [NUM_SETS][NUM_WAYS];
  logic [MAIN_MEM_DATA_WIDTH-1:0]    data_q [NUM_SETS][NUM_WAYS];

  logic [NUM_WAYS-1:0] hit_vec;
  logic                hit;
  logic [WAY_W-1:0]    hit_way, lru_way, victim_sel;
  logic                lru_upd, wr_hit, fill_we;
  logic                unused_ok;

  // Byte-offset bits never select anything: the port is word-granular.
  assign unused_ok = ^cpu_addr[BYTE_OFF-1:0];

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit_vec[w] = valid_q[req_idx_q][w] && (tag_q[req_idx_q][w] == req_tag_q);
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end
  assign hit = |hit_vec;

  // Lowest-index invalid way wins over the LRU way.
  always_comb begin
    victim_sel = lru_way;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[req_idx_q][w]) victim_sel = WAY_W'(w);
  end

  always_comb begin
    state_d     = state_q;
    req_rw_d    = req_rw_q;
    req_tag_d   = req_tag_q;
    req_idx_d   = req_idx_q;
    req_word_d  = req_word_q;
    req_wdata_d = req_wdata_q;
    victim_d    = victim_q;
    mem_gap_d   = 1'b0;
    cpu_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    lru_upd     = 1'b0;
    wr_hit      = 1'b0;
    fill_we     = 1'b0;
    mem_valid   = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        if (cpu_valid) begin
          req_rw_d    = cpu_rw;
          req_tag_d   = cpu_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
          req_idx_d   = cpu_addr[OFF_W +: INDEX_WIDTH];
          req_word_d  = cpu_addr[BYTE_OFF +: WORD_OFF];
          req_wdata_d = cpu_wdata;
          state_d     = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          cpu_ready_d = 1'b1;
          lru_upd     = 1'b1;
          if (req_rw_q) wr_hit = 1'b1;
          else cpu_rdata_d = data_q[req_idx_q][hit_way][req_word_q*DATA_WIDTH +: DATA_WIDTH];
          state_d = S_IDLE;
        end else begin
          victim_d = victim_sel;
          state_d  = (valid_q[req_idx_q][victim_sel] && dirty_q[req_idx_q][victim_sel])
                     ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        mem_valid = 1'b1;
        mem_rw    = 1'b1;
        mem_addr  = {tag_q[req_idx_q][victim_q], req_idx_q, {OFF_W{1'b0}}};
        mem_wdata = data_q[req_idx_q][victim_q];
        if (mem_ready) begin
          mem_gap_d = 1'b1;
          state_d   = S_ALLOCATE;
        end
      end
      default: begin
        // One idle cycle after a writeback ack before the fill request goes out.
        if (!mem_gap_q) begin
          mem_valid = 1'b1;
          mem_addr  = {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
          if (mem_ready) begin
            fill_we = 1'b1;
            state_d = S_COMPARE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_rw_q    <= 1'b0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      mem_gap_q   <= 1'b0;
      cpu_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_rw_q    <= req_rw_d;
      req_tag_q   <= req_tag_d;
      req_idx_q   <= req_idx_d;
      req_word_q  <= req_word_d;
      req_wdata_q <= req_wdata_d;
      victim_q    <= victim_d;
      mem_gap_q   <= mem_gap_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      if (fill_we) begin
        valid_q[req_idx_q][victim_q] <= 1'b1;
        dirty_q[req_idx_q][victim_q] <= 1'b0;
      end
      if (wr_hit) dirty_q[req_idx_q][hit_way] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[req_idx_q][victim_q]  <= req_tag_q;
      data_q[req_idx_q][victim_q] <= mem_rdata;
    end
    if (wr_hit)
      data_q[req_idx_q][hit_way][req_word_q*DATA_WIDTH +: DATA_WIDTH] <= req_wdata_q;
  end

  generate
    if (NUM_WAYS > 1) begin : g_lru
      logic [NUM_SETS-1:0][NUM_WAYS-1:0][WAY_W-1:0] age_q, age_d;

      // Ages form a permutation per set; the oldest way carries NUM_WAYS-1.
      always_comb begin
        age_d = age_q;
        if (lru_upd)
          for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAY_W'(w) == hit_way) age_d[req_idx_q][w] = '0;
            else if (age_q[req_idx_q][w] < age_q[req_idx_q][hit_way])
              age_d[req_idx_q][w] = age_q[req_idx_q][w] + 1'b1;
          end
      end

      always_comb begin
        lru_way = '0;
        for (int w = 0; w < NUM_WAYS; w++)
          if (age_q[req_idx_q][w] == WAY_W'(NUM_WAYS - 1)) lru_way = WAY_W'(w);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < NUM_SETS; s++)
            for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
        end else begin
          age_q <= age_d;
        end
      end
    end else begin : g_no_lru
      assign lru_way = '0;
    end
  endgenerate

`ifdef CACHE_STATS_EN
  logic        first_q, first_d;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // Only the COMPARE that directly follows acceptance is scored.
  always_comb begin
    first_d    = first_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_IDLE && cpu_valid) first_d = 1'b1;
    if (state_q == S_COMPARE) begin
      first_d = 1'b0;
      if (first_q && hit && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      if (first_q && !hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      first_q    <= first_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  assign cpu_ready = cpu_ready_q;
  assign cpu_rdata = cpu_rdata_q;

endmodule

// File: tb/tb_cache_ctrl_set_assoc.sv
// Bench for cache_ctrl_set_assoc: directed walk-through, then random traffic against a
// line/LRU-list reference model with an inline memory responder.
module tb_cache_ctrl_set_assoc;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cpu_valid = 1'b0, cpu_rw = 1'b0;
  logic [31:0]  cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic         cpu_ready, mem_valid, mem_rw;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata = '0;
  logic         mem_ready = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_ctrl_set_assoc dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: 4 sets x 2 ways, LRU kept as a per-set MRU-first list of way numbers.
  logic [127:0] mem_m [logic [31:0]];
  logic [127:0] m_data  [4][2];
  bit           m_valid [4][2];
  bit           m_dirty [4][2];
  int unsigned  m_tag   [4][2];
  int           lru_q   [4][$];
  logic [31:0]  last_wb_addr = '0, last_fill_addr = '0;
  logic [127:0] last_wb_data = '0;
  int           last_lat = 0;

  function automatic logic [127:0] mem_block(input logic [31:0] ba);
    if (mem_m.exists(ba)) return mem_m[ba];
    return {ba ^ 32'h0D0D_0003, ba ^ 32'h0C0C_0002, ba ^ 32'h0B0B_0001, ba ^ 32'h0A0A_0000};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
      lru_q[s].delete();
      lru_q[s].push_back(0);
      lru_q[s].push_back(1);
    end
  endtask

  task automatic do_req(input bit rw, input logic [31:0] a, input logic [31:0] wd);
    int unsigned idx, tag, word;
    int w, cyc, wb_seen, fill_seen, d;
    bit hit, exp_wb, got;
    logic [31:0] wb_a, fill_a, exp_rd;
    logic [127:0] wb_d, fill_blk, blk;
    idx = (a >> 4) & 3;
    tag = a >> 6;
    word = (a >> 2) & 3;
    hit = 0; w = 0; exp_wb = 0; wb_a = '0; wb_d = '0; fill_blk = '0;
    fill_a = a & 32'hFFFF_FFF0;
    for (int i = 0; i < 2; i++)
      if (m_valid[idx][i] && m_tag[idx][i] == tag) begin hit = 1; w = i; end
    if (!hit) begin
      w = lru_q[idx][$];
      for (int i = 1; i >= 0; i--) if (!m_valid[idx][i]) w = i;
      if (m_valid[idx][w] && m_dirty[idx][w]) begin
        exp_wb = 1;
        wb_a = (m_tag[idx][w] << 6) | (idx << 4);
        wb_d = m_data[idx][w];
        mem_m[wb_a] = wb_d;
      end
      fill_blk = mem_block(fill_a);
      m_data[idx][w] = fill_blk;
      m_valid[idx][w] = 1;
      m_dirty[idx][w] = 0;
      m_tag[idx][w] = tag;
    end
    for (int k = 0; k < lru_q[idx].size(); k++)
      if (lru_q[idx][k] == w) begin lru_q[idx].delete(k); break; end
    lru_q[idx].push_front(w);
    blk = m_data[idx][w];
    exp_rd = blk[word*32 +: 32];
    if (rw) begin
      blk[word*32 +: 32] = wd;
      m_data[idx][w] = blk;
      m_dirty[idx][w] = 1;
    end

    cpu_valid = 1'b1;
    cpu_rw    = rw;
    cpu_addr  = (a & 32'hFFFF_FFFC) | ($urandom & 32'h3);
    cpu_wdata = wd;
    @(posedge clk); #1;
    // Garbage on the cpu side while busy must be ignored.
    cpu_valid = 1'b0;
    cpu_rw    = 1'($urandom);
    cpu_addr  = $urandom;
    cpu_wdata = $urandom;
    cyc = 1; got = 0; wb_seen = 0; fill_seen = 0;
    while (!got && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      mem_ready = 1'b0;
      if (cpu_ready) begin
        got = 1;
        chk("rdy_vs_mem", mem_valid, 0);
      end else if (mem_valid) begin
        d = $urandom_range(0, 2);
        repeat (d) begin @(posedge clk); #1; end
        cyc += d;
        if (mem_rw) begin
          wb_seen++;
          chk("wb_addr", mem_addr, wb_a);
          chk("wb_data", mem_wdata, wb_d);
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
        end else begin
          fill_seen++;
          chk("fill_addr", mem_addr, fill_a);
          last_fill_addr = mem_addr;
          mem_rdata = fill_blk;
        end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        cyc++;
        chk("vld_drop", mem_valid, 0);
        // Stray ack while no request is outstanding.
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    mem_ready = 1'b0;
    chk("ready", got, 1);
    chk("wb_cnt", wb_seen, exp_wb ? 1 : 0);
    chk("fill_cnt", fill_seen, hit ? 0 : 1);
    if (hit) chk("hit_lat", cyc, 2);
    if (!rw) chk("rdata", cpu_rdata, exp_rd);
    last_lat = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    model_reset();
    mem_m[32'h10] = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_mvalid", mem_valid, 0);
    chk("rst_mrw", mem_rw, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(0, 32'h10, 0);
    chk("s1_fill", last_fill_addr, 32'h10);
    chk("s1_rdata", cpu_rdata, 32'h1111_1111);
    do_req(0, 32'h18, 0);
    chk("s2_lat", last_lat, 2);
    chk("s2_rdata", cpu_rdata, 32'h3333_3333);
    do_req(1, 32'h14, 32'hCAFE_F00D);
    do_req(0, 32'h14, 0);
    chk("s3_rdata", cpu_rdata, 32'hCAFE_F00D);
    do_req(0, 32'h50, 0);
    do_req(0, 32'h90, 0);
    chk("s4_wb_addr", last_wb_addr, 32'h10);
    chk("s4_wb_data", last_wb_data,
        {32'h4444_4444, 32'h3333_3333, 32'hCAFE_F00D, 32'h1111_1111});
    chk("s4_fill", last_fill_addr, 32'h90);
    do_req(0, 32'h50, 0);
    chk("s4_lat", last_lat, 2);
`ifdef CACHE_STATS_EN
    chk("s6_hits", hit_count, 4);
    chk("s6_misses", miss_count, 3);
`endif

    cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h110;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    for (int i = 0; i < 10 && !mem_valid; i++) begin @(posedge clk); #1; end
    chk("s5_alloc", {mem_valid, mem_rw}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_mvalid", mem_valid, 0);
    chk("s5_rst_ready", cpu_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    do_req(0, 32'h50, 0);
    chk("s5_refill", last_fill_addr, 32'h50);
`ifdef CACHE_STATS_EN
    chk("s5_hits", hit_count, 0);
    chk("s5_misses", miss_count, 1);
`endif

    repeat (300) begin
      a = ($urandom_range(0, 7) << 6) | ($urandom_range(0, 1) << 31) | ($urandom & 32'h3C);
      do_req(1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
